// File: rtl/mul_pkg.sv
// Shared types for the iterative multiplier: op encoding and FSM states.
// Helper functions decide which operands are treated as signed for each op.
// Build option: MUL_UNIT_EARLY_EXIT_EN (see mul_unit.sv).
package mul_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } mul_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } mul_state_e;

    // rs1 is signed for MULH and MULHSU
    function automatic logic x_is_signed(mul_op_e op);
        return (op == MULH) || (op == MULHSU);
    endfunction

    // rs2 is signed for MULH only
    function automatic logic y_is_signed(mul_op_e op);
        return (op == MULH);
    endfunction

endpackage

// File: rtl/mul_operand_prep.sv
// Operand conditioning: converts signed operands to magnitudes and derives
// the final negate flag. Purely combinational, zero latency, no backpressure.
// MUL_UNIT_EARLY_EXIT_EN has no effect here.
import mul_pkg::*;

module mul_operand_prep #(
    parameter int XLEN = 32
) (
    input  mul_op_e           op,
    input  logic [XLEN-1:0]   x,
    input  logic [XLEN-1:0]   y,
    output logic [XLEN-1:0]   x_mag,
    output logic [XLEN-1:0]   y_mag,
    output logic              negate
);

    localparam logic [XLEN-1:0] ONE = {{(XLEN-1){1'b0}}, 1'b1};

    logic x_neg;
    logic y_neg;

    // Magnitude of the most negative value is still representable unsigned.
    always_comb begin
        x_neg  = x_is_signed(op) & x[XLEN-1];
        y_neg  = y_is_signed(op) & y[XLEN-1];
        x_mag  = x_neg ? (~x + ONE) : x;
        y_mag  = y_neg ? (~y + ONE) : y;
        negate = x_neg ^ y_neg;
    end

endmodule

// File: rtl/mul_unit.sv
// Iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU (RV-M style).
// Latency: done pulses N+2 cycles after the start edge (N = XLEN/BITS_PER_CYCLE).
// No queuing: start is ignored while busy. MUL_UNIT_EARLY_EXIT_EN ends RUN once the multiplier is exhausted.
import mul_pkg::*;

module mul_unit #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   x,
    input  logic [XLEN-1:0]   y,
    output logic              busy,
    output logic              done,
    output logic [XLEN-1:0]   result
);

    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    localparam int PW = 2 * XLEN;

    mul_state_e         state;
    logic [PW-1:0]      mcand;
    logic [XLEN-1:0]    mplier;
    logic [PW-1:0]      prod;
    logic               negate_q;
    logic               high_q;
    logic [CW-1:0]      cnt;
    logic [XLEN-1:0]    result_q;

    logic [XLEN-1:0]    x_mag;
    logic [XLEN-1:0]    y_mag;
    logic               negate;
    logic [PW-1:0]      step_sum;
    logic [XLEN-1:0]    mplier_nxt;
    logic               last_step;
    logic [PW-1:0]      signed_prod;

    // bit 2 of funct3 carries no meaning for this unit
    logic unused_funct3;
    assign unused_funct3 = funct3[2];

    mul_operand_prep #(
        .XLEN (XLEN)
    ) u_prep (
        .op     (mul_op_e'(funct3[1:0])),
        .x      (x),
        .y      (y),
        .x_mag  (x_mag),
        .y_mag  (y_mag),
        .negate (negate)
    );

    // One RUN step: add shifted multiplicand for each set multiplier bit; decide whether RUN ends.
    always_comb begin
        step_sum = prod;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier[i]) begin
                step_sum = step_sum + (mcand << i);
            end
        end
        mplier_nxt = mplier >> BITS_PER_CYCLE;
        last_step  = (cnt == CW'(N - 1));
`ifdef MUL_UNIT_EARLY_EXIT_EN
        last_step  = last_step | (mplier_nxt == '0);
`else
        last_step  = last_step | 1'b0;
`endif
        signed_prod = negate_q ? (~prod + {{(PW-1){1'b0}}, 1'b1}) : prod;
    end

    // FSM and datapath: capture in IDLE, accumulate in RUN, apply sign and select half in SIGN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mcand    <= '0;
            mplier   <= '0;
            prod     <= '0;
            negate_q <= 1'b0;
            high_q   <= 1'b0;
            cnt      <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand    <= {{XLEN{1'b0}}, x_mag};
                        mplier   <= y_mag;
                        prod     <= '0;
                        negate_q <= negate;
                        high_q   <= (funct3[1:0] != 2'b00);
                        cnt      <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    prod   <= step_sum;
                    mcand  <= mcand << BITS_PER_CYCLE;
                    mplier <= mplier_nxt;
                    cnt    <= cnt + CW'(1);
                    if (last_step) begin
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    prod     <= signed_prod;
                    result_q <= high_q ? signed_prod[PW-1:XLEN] : signed_prod[XLEN-1:0];
                    state    <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_mul_unit.sv
// Directed bench for mul_unit (XLEN=32, BITS_PER_CYCLE=1) with an arithmetic reference model.
// Model tracks accept/done timing and the expected result; a per-cycle checker compares outputs.
// Optional build: MUL_UNIT_EARLY_EXIT_EN changes the expected RUN length.
import mul_pkg::*;

module tb_mul_unit;

    localparam int XLEN = 32;
`ifdef MUL_UNIT_EARLY_EXIT_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 34;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [2:0]      funct3 = 3'd0;
    logic [XLEN-1:0] x = '0;
    logic [XLEN-1:0] y = '0;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    int checks = 0;
    int passed = 0;

    mul_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(1)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .x      (x),
        .y      (y),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // Reference: exact 2*XLEN product of the sign-extended operands.
    function automatic logic [31:0] model_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [64:0]  ea;
        logic signed [64:0]  eb;
        logic signed [129:0] p;
        ea = (f[1:0] == 2'd1 || f[1:0] == 2'd2) ? $signed({{33{a[31]}}, a}) : $signed({33'b0, a});
        eb = (f[1:0] == 2'd1) ? $signed({{33{b[31]}}, b}) : $signed({33'b0, b});
        p  = ea * eb;
        return (f[1:0] == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // Cycles spent in RUN for this operation.
    function automatic int model_runs(input logic [2:0] f, input logic [31:0] b);
`ifdef MUL_UNIT_EARLY_EXIT_EN
        logic [31:0] mag;
        int r;
        mag = (f[1:0] == 2'd1 && b[31]) ? (32'd0 - b) : b;
        r = 1;
        for (int i = 0; i < 32; i++) if (mag[i]) r = i + 1;
        return r;
`else
        return (f[1:0] == 2'd0 && b == 32'hDEAD_BEEF) ? 32 : 32;
`endif
    endfunction

    int          edge_n = 0;
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    bit          was_busy;
    logic [31:0] m_res = '0;
    logic [31:0] m_pend = '0;
    int          m_done_edge = 0;
    int          m_idle_edge = 0;

    // Model: one operation in flight, start honoured only when idle before the edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_res  = '0;
        end else begin
            was_busy = m_busy;
            edge_n++;
            if (m_busy && edge_n == m_idle_edge) begin
                m_busy = 1'b0;
                m_done = 1'b0;
            end
            if (m_busy && edge_n == m_done_edge) begin
                m_done = 1'b1;
                m_res  = m_pend;
            end
            if (!was_busy && start) begin
                m_busy      = 1'b1;
                m_pend      = model_result(funct3, x, y);
                m_done_edge = edge_n + model_runs(funct3, y) + 1;
                m_idle_edge = m_done_edge + 1;
            end
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(posedge clk) begin
        #2;
        if (!rst) begin
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("result", result, m_res);
        end
    end

    task automatic wait_done(input int s, input string name, input logic [31:0] exp, input int exp_cyc);
        int k;
        k = 0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            check({name, "_timeout"}, 0, 1);
        end else begin
            check({name, "_result"}, result, exp);
            check({name, "_model"}, m_res, exp);
            if (exp_cyc != 0) check({name, "_cycle"}, edge_n - s + 1, exp_cyc);
        end
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_cyc, input string name, output int s);
        @(negedge clk);
        funct3 = f; x = a; y = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s = edge_n;
        wait_done(s, name, exp, exp_cyc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0, s1, s2, ndone;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        rst = 1'b0;
        @(negedge clk);

        run_op(3'd0, 32'd7, 32'd6, 32'h0000_002A, LAT, "mul_7x6", s0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, LAT, "mulh_m1", s0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT, "mulhsu_m1", s0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT, "mulhu_m1", s0);
        run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, LAT, "mul_m1", s0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT, "mulh_min", s0);
        run_op(3'd0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, LAT, "mul_min", s0);
        run_op(3'd2, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, LAT, "mulhsu_neg", s0);
        run_op(3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, LAT, "mul_neg", s0);
        run_op(3'd1, 32'd3, 32'hFFFF_FFF9, 32'hFFFF_FFFF, LAT, "mulh_yneg", s0);
        run_op(3'd2, 32'd3, 32'hFFFF_FFF9, 32'h0000_0002, LAT, "mulhsu_yuns", s0);
        run_op(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT, "f3bit2", s0);
        run_op(3'd3, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, LAT, "mulhu_2p32", s0);
        run_op(3'd0, 32'd5, 32'd2, 32'h0000_000A, LAT, "mul_5x2", s0);
`ifdef MUL_UNIT_EARLY_EXIT_EN
        run_op(3'd0, 32'd5, 32'd0, 32'h0000_0000, 3, "mul_5x0", s0);
        run_op(3'd0, 32'd5, 32'd2, 32'h0000_000A, 4, "mul_5x2_ee", s0);
`else
        run_op(3'd0, 32'd5, 32'd0, 32'h0000_0000, 34, "mul_5x0", s0);
`endif

        // Start pulsed again mid-operation with new operands must be ignored.
        @(negedge clk);
        funct3 = 3'd0; x = 32'd3; y = 32'h8000_0005; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s1 = edge_n;
        repeat (8) @(negedge clk);
        funct3 = 3'd3; x = 32'd100; y = 32'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(s1, "ignore", 32'h8000_000F, 34);
        // Back-to-back: start in the cycle right after DONE.
        run_op(3'd3, 32'h0001_0000, 32'h0002_0000, 32'h0000_0002, 34, "b2b", s2);
        check("b2b_start_gap", s2 - s1, 35);
        check("b2b_done_cycle", edge_n - s1 + 1, 69);

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        funct3 = 3'd0; x = 32'd7; y = 32'h8000_0009; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s1 = edge_n;
        repeat (13) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_result", result, 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("no_done_after_rst", ndone, 0);

        // Start accepted on the first edge after reset release.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        funct3 = 3'd3; x = 32'h0001_0000; y = 32'h0003_0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s2 = edge_n;
        wait_done(s2, "post_rst", 32'h0000_0003, LAT);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
